// File: rtl/lcd_sched_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lcd_sched_pkg
//  Purpose  : Shared widths, FSM state encoding and helpers for lcd_print_sched
//  Revision : 1.0  initial release
// ============================================================================
package lcd_sched_pkg;

    localparam int VAL_W   = 32;
    localparam int LINE_W  = 128;
    localparam int CNT_W   = 32;
    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_CONV  = 2'd1;
    localparam logic [STATE_W-1:0] ST_SHOW  = 2'd2;
    localparam logic [STATE_W-1:0] ST_DWELL = 2'd3;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_print_sched_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin select of the next requester after the last grant
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import lcd_sched_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req,
    input  logic                    advance,
    output logic [N-1:0]            gnt_oh,
    output logic [idx_width(N)-1:0] gnt_idx,
    output logic                    gnt_any
);

    localparam int c_IDX_W = idx_width(N);
    localparam int c_NP    = 1 << c_IDX_W;

    logic [c_IDX_W-1:0] r_last;
    logic [c_NP-1:0]    w_req_pad;
    logic [c_IDX_W:0]   w_pos;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_any;

    assign w_req_pad = c_NP'(req);

    // Search starts one past the last winner and wraps modulo N.
    always_comb begin
        w_pos = '0;
        w_idx = '0;
        w_any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            w_pos = {1'b0, r_last} + (c_IDX_W+1)'(k);
            if (w_pos >= (c_IDX_W+1)'(N)) begin
                w_pos = w_pos - (c_IDX_W+1)'(N);
            end
            if (!w_any && w_req_pad[w_pos[c_IDX_W-1:0]]) begin
                w_any = 1'b1;
                w_idx = w_pos[c_IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= c_IDX_W'(N - 1);
        end else if (advance && w_any) begin
            r_last <= w_idx;
        end
    end

    assign gnt_oh  = N'(w_any) << w_idx;
    assign gnt_idx = w_idx;
    assign gnt_any = w_any;

endmodule
`default_nettype wire

// File: rtl/lcd_print_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lcd_print_sched
//  Purpose  : Shares one bin_to_dec and one lcd_driver among N_REQ requesters:
//             convert, print, dwell. Optional watchdog: LCD_SCHED_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module lcd_print_sched
    import lcd_sched_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int DWELL_CYCLES   = 50000000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [VAL_W*N_REQ-1:0]  value_flat,
    input  logic [LINE_W*N_REQ-1:0] label_flat,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic                    busy,
    output logic                    conv_start,
    output logic [VAL_W-1:0]        conv_value,
    input  logic [LINE_W-1:0]       conv_ascii,
    input  logic                    conv_ready,
    output logic                    lcd_ready,
    output logic [LINE_W-1:0]       lcd_line1,
    output logic [LINE_W-1:0]       lcd_line2,
    input  logic                    lcd_done,
    output logic [N_REQ-1:0]        timeout_err
);

    localparam int c_IDX_W = idx_width(N_REQ);

    if (N_REQ < 1 || N_REQ > 8) begin : g_bad_n_req
        $error("lcd_print_sched: N_REQ must be 1..8");
    end
    if (DWELL_CYCLES < 0 || TIMEOUT_CYCLES < 0) begin : g_bad_cycles
        $error("lcd_print_sched: cycle counts must be non-negative");
    end

    logic [STATE_W-1:0] r_state;
    logic [N_REQ-1:0]   r_cur_oh;
    logic [CNT_W-1:0]   r_dwell;
    logic [N_REQ-1:0]   w_gnt_oh;
    logic [c_IDX_W-1:0] w_gnt_idx;
    logic               w_gnt_any;
    logic               w_advance;

    assign w_advance = (r_state == ST_IDLE);

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (w_advance),
        .gnt_oh  (w_gnt_oh),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

`ifdef LCD_SCHED_TIMEOUT_EN
    logic [CNT_W-1:0] r_wdog;
    logic [CNT_W-1:0] w_wdog_inc;
    logic             w_wdog_hit;

    // Saturating count; the hit compare is done one bit wider so 0 never wraps.
    assign w_wdog_inc = (r_wdog == '1) ? r_wdog : r_wdog + 1'b1;
    assign w_wdog_hit = ({1'b0, r_wdog} + 33'd1) >= 33'(TIMEOUT_CYCLES);
`else
    assign timeout_err = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cur_oh    <= '0;
            r_dwell     <= '0;
            grant       <= '0;
            done        <= '0;
            busy        <= 1'b0;
            conv_start  <= 1'b0;
            conv_value  <= '0;
            lcd_ready   <= 1'b0;
            lcd_line1   <= '0;
            lcd_line2   <= '0;
`ifdef LCD_SCHED_TIMEOUT_EN
            r_wdog      <= '0;
            timeout_err <= '0;
`endif
        end else begin
            grant <= '0;
            done  <= '0;
`ifdef LCD_SCHED_TIMEOUT_EN
            timeout_err <= '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_any) begin
                        grant      <= w_gnt_oh;
                        r_cur_oh   <= w_gnt_oh;
                        conv_value <= value_flat[int'(w_gnt_idx)*VAL_W +: VAL_W];
                        lcd_line1  <= label_flat[int'(w_gnt_idx)*LINE_W +: LINE_W];
                        conv_start <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= ST_CONV;
`ifdef LCD_SCHED_TIMEOUT_EN
                        r_wdog     <= '0;
`endif
                    end
                end

                ST_CONV: begin
                    if (conv_ready) begin
                        lcd_line2  <= conv_ascii;
                        conv_start <= 1'b0;
                        lcd_ready  <= 1'b1;
                        r_state    <= ST_SHOW;
`ifdef LCD_SCHED_TIMEOUT_EN
                        r_wdog     <= '0;
                    end else if (w_wdog_hit) begin
                        timeout_err <= r_cur_oh;
                        conv_start  <= 1'b0;
                        busy        <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wdog      <= w_wdog_inc;
`endif
                    end
                end

                ST_SHOW: begin
                    if (lcd_done) begin
                        lcd_ready <= 1'b0;
                        if (DWELL_CYCLES == 0) begin
                            done    <= r_cur_oh;
                            busy    <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_dwell <= CNT_W'(DWELL_CYCLES - 1);
                            r_state <= ST_DWELL;
                        end
`ifdef LCD_SCHED_TIMEOUT_EN
                    end else if (w_wdog_hit) begin
                        timeout_err <= r_cur_oh;
                        lcd_ready   <= 1'b0;
                        busy        <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wdog      <= w_wdog_inc;
`endif
                    end
                end

                ST_DWELL: begin
                    // Counter is loaded with DWELL_CYCLES-1 so the hold spans exactly DWELL_CYCLES.
                    if (r_dwell == '0) begin
                        done    <= r_cur_oh;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_dwell <= r_dwell - 1'b1;
                    end
                end

                default: begin
                    conv_start <= 1'b0;
                    lcd_ready  <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_print_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_print_sched
//  Purpose  : Directed table-driven bench for lcd_print_sched (dwell 20 and 0)
//  Revision : 1.0  initial release
// ============================================================================
module tb_lcd_print_sched;

    localparam int N  = 2;
    localparam int DW = 20;

    localparam logic [127:0] LBL0  = "Dhruv    Pragati";
    localparam logic [127:0] LBL1  = "Requester one   ";

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N-1:0]     req;
    logic [32*N-1:0]  value_flat;
    logic [128*N-1:0] label_flat;
    logic [N-1:0]     grant, done, timeout_err;
    logic             busy, conv_start, lcd_ready;
    logic [31:0]      conv_value;
    logic [127:0]     conv_ascii, lcd_line1, lcd_line2;
    logic             conv_ready, lcd_done;

    logic [N-1:0]     z_req, z_grant, z_done, z_timeout_err;
    logic             z_busy, z_conv_start, z_lcd_ready, z_conv_ready, z_lcd_done;
    logic [31:0]      z_conv_value;
    logic [127:0]     z_lcd_line1, z_lcd_line2;

    lcd_print_sched #(
        .N_REQ(N), .DWELL_CYCLES(DW), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .value_flat(value_flat), .label_flat(label_flat),
        .grant(grant), .done(done), .busy(busy), .conv_start(conv_start),
        .conv_value(conv_value), .conv_ascii(conv_ascii), .conv_ready(conv_ready),
        .lcd_ready(lcd_ready), .lcd_line1(lcd_line1), .lcd_line2(lcd_line2),
        .lcd_done(lcd_done), .timeout_err(timeout_err)
    );

    lcd_print_sched #(
        .N_REQ(N), .DWELL_CYCLES(0), .TIMEOUT_CYCLES(50)
    ) dut0 (
        .clk(clk), .rst(rst), .req(z_req), .value_flat(value_flat), .label_flat(label_flat),
        .grant(z_grant), .done(z_done), .busy(z_busy), .conv_start(z_conv_start),
        .conv_value(z_conv_value), .conv_ascii(conv_ascii), .conv_ready(z_conv_ready),
        .lcd_ready(z_lcd_ready), .lcd_line1(z_lcd_line1), .lcd_line2(z_lcd_line2),
        .lcd_done(z_lcd_done), .timeout_err(z_timeout_err)
    );

    typedef struct {
        logic [N-1:0] req;
        logic [31:0]  v0;
        logic [31:0]  v1;
        logic [N-1:0] exp_gnt;
        logic [31:0]  exp_val;
        logic [127:0] exp_lbl;
        logic [127:0] ascii;
        logic         drop;
    } vec_t;

    vec_t tbl [7];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        int cnt;
        req        = v.req;
        value_flat = {v.v1, v.v0};
        tick();
        check("grant", grant, v.exp_gnt);
        check("conv_value", conv_value, v.exp_val);
        check("lcd_line1", lcd_line1, v.exp_lbl);
        check("conv_busy", {conv_start, lcd_ready, busy}, 3'b101);
        if (v.drop) req = '0;
        lcd_done = 1'b1; tick(); lcd_done = 1'b0;
        check("conv_hold", {conv_start, lcd_ready, busy}, 3'b101);
        repeat (8) tick();
        conv_ascii = v.ascii; conv_ready = 1'b1; tick(); conv_ready = 1'b0; conv_ascii = '0;
        check("lcd_line2", lcd_line2, v.ascii);
        check("show_enter", {conv_start, lcd_ready}, 2'b01);
        conv_ready = 1'b1; tick(); conv_ready = 1'b0;
        check("show_hold", {lcd_ready, done}, {1'b1, {N{1'b0}}});
        check("line2_stray", lcd_line2, v.ascii);
        tick();
        lcd_done = 1'b1; tick(); lcd_done = 1'b0;
        check("show_exit", {lcd_ready, done}, {1'b0, {N{1'b0}}});
        cnt = 0;
        while (done == '0 && cnt < 100) begin
            tick();
            cnt++;
        end
        check("dwell_len", cnt, DW);
        check("done", done, v.exp_gnt);
        check("dwell_lines", {lcd_line1, lcd_line2}, {v.exp_lbl, v.ascii});
        check("idle_busy", {busy, timeout_err}, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        tbl[0] = '{2'b01, 32'd928,    32'd5,          2'b01, 32'd928,        LBL0, "             928", 1'b0};
        tbl[1] = '{2'b11, 32'd1,      32'hFFFF_FFFF,  2'b10, 32'hFFFF_FFFF,  LBL1, "      4294967295", 1'b0};
        tbl[2] = '{2'b11, 32'd0,      32'd7,          2'b01, 32'd0,          LBL0, "               0", 1'b0};
        tbl[3] = '{2'b11, 32'd12,     32'd345,        2'b10, 32'd345,        LBL1, "             345", 1'b0};
        tbl[4] = '{2'b10, 32'd99,     32'd65536,      2'b10, 32'd65536,      LBL1, "           65536", 1'b0};
        tbl[5] = '{2'b01, 32'd42,     32'd8,          2'b01, 32'd42,         LBL0, "              42", 1'b0};
        tbl[6] = '{2'b01, 32'd100000, 32'd3,          2'b01, 32'd100000,     LBL0, "          100000", 1'b1};

        rst = 1'b1; req = '0; z_req = '0;
        value_flat = {32'd5, 32'd928}; label_flat = {LBL1, LBL0};
        conv_ascii = '0; conv_ready = 1'b0; lcd_done = 1'b0;
        z_conv_ready = 1'b0; z_lcd_done = 1'b0;
        repeat (2) tick();
        check("rst_pulses", {grant, done, timeout_err}, '0);
        check("rst_ctrl", {busy, conv_start, lcd_ready}, 3'b000);
        check("rst_data", {conv_value, lcd_line1, lcd_line2}, '0);
        rst = 1'b0;

        // Zero dwell: done on the edge after lcd_done, regrant one cycle later.
        z_req = 2'b01;
        tick();
        check("z_grant", z_grant, 2'b01);
        z_conv_ready = 1'b1; tick(); z_conv_ready = 1'b0;
        check("z_show", {z_conv_start, z_lcd_ready}, 2'b01);
        z_lcd_done = 1'b1; tick(); z_lcd_done = 1'b0;
        check("z_done", {z_done, z_busy, z_lcd_ready}, {2'b01, 1'b0, 1'b0});
        tick();
        check("z_regrant", {z_grant, z_busy}, {2'b01, 1'b1});
        z_req = '0;
        z_conv_ready = 1'b1; tick(); z_conv_ready = 1'b0;
        z_lcd_done = 1'b1; tick(); z_lcd_done = 1'b0;
        check("z_done2", z_done, 2'b01);

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Reset while SHOW: no done, pointer back to requester 0.
        req = 2'b10;
        tick();
        check("mid_grant", grant, 2'b10);
        conv_ascii = "               7"; conv_ready = 1'b1; tick(); conv_ready = 1'b0;
        check("mid_show", lcd_ready, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_ctrl", {lcd_ready, busy, conv_start, done, grant}, '0);
        check("mid_rst_data", {conv_value, lcd_line1, lcd_line2}, '0);
        req = 2'b11;
        tick();
        check("post_rst_grant", {grant, done}, {2'b01, 2'b00});
        req = '0;
        conv_ready = 1'b1; tick(); conv_ready = 1'b0;
        lcd_done = 1'b1; tick(); lcd_done = 1'b0;
        repeat (DW) tick();
        check("post_rst_done", {done, busy}, {2'b01, 1'b0});

`ifdef LCD_SCHED_TIMEOUT_EN
        begin
            int cnt;
            req = 2'b01;
            tick();
            check("to_grant", grant, 2'b01);
            req = '0;
            cnt = 0;
            while (timeout_err == '0 && cnt < 200) begin
                tick();
                cnt++;
            end
            check("to_len", cnt, 50);
            check("to_err", timeout_err, 2'b01);
            check("to_abort", {conv_start, lcd_ready, busy, done}, '0);
            tick();
            check("to_idle", {busy, grant, done, timeout_err}, '0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
